airlock_sequencer: RTL and testbench

- Chamber-level sequencer that sits directly upstream of the evacuate and pressurize stages.
- Accepts occupant exit/enter requests and drives the inner and outer doors.
- Issues level-held evacuate/pressurize commands and consumes their pressurized/evacuated status.
- Enforces the door interlock and a pump-timeout fault.

---
 rtl/airlock_pkg.sv | 31 +++
 rtl/airlock_cycle_timer.sv | 30 +++
 rtl/airlock_sequencer.sv | 166 ++++++++++++++++
 tb/tb_airlock_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock chamber sequencer.
//   state_t : sequencer FSM states
//   dir_t   : direction of the trip in progress (NONE = chamber repositioning only)
//   cnt_width() : width of the shared dwell/timeout counter
package airlock_pkg;

    typedef enum logic [2:0] {
        READY_P    = 3'd0,
        INNER_OPEN = 3'd1,
        EVAC       = 3'd2,
        READY_V    = 3'd3,
        OUTER_OPEN = 3'd4,
        PRESS      = 3'd5,
        FAULT      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IN   = 2'd1,
        OUT  = 2'd2
    } dir_t;

    localparam int DOOR_CYC_DEF = 8;
    localparam int TIMEOUT_DEF  = 64;

    // Counter must hold the larger of the two limits.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/airlock_cycle_timer.sv
// Loadable up-counter with a limit compare.
//   clk, rst : clock, async active-high reset
//   load     : restart counting; the cycle after load counts as cycle 1
//   limit    : cycle number at which done asserts
//   done     : high on the limit-th cycle since load (and after, counter holds)
module airlock_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = (cnt >= limit);

    // Saturate at the limit so a long dwell in a ready state cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= W'(1);
        else if (!done)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: serves occupant exit/enter requests by cycling
// the doors and the evacuate/pressurize stages, with door interlock and a
// sticky pump-timeout fault.
//   clk, rst          : clock, async active-high reset
//   req_exit          : pulse, occupant on pressurized side wants out
//   req_enter         : pulse, occupant on vacuum side wants in
//   pressurized       : level status from the pressurize stage
//   evacuated         : level status from the evacuate stage
//   evacuate_ctrl     : high while evacuating
//   pressurize_ctrl   : high while pressurizing
//   inner_door_open   : habitat-side door command
//   outer_door_open   : vacuum-side door command
//   at_vacuum         : chamber resting at vacuum
//   busy              : sequence in progress
//   fault             : sticky pump timeout
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int DOOR_CYC = DOOR_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_exit,
    input  logic req_enter,
    input  logic pressurized,
    input  logic evacuated,
    output logic evacuate_ctrl,
    output logic pressurize_ctrl,
    output logic inner_door_open,
    output logic outer_door_open,
    output logic at_vacuum,
    output logic busy,
    output logic fault
);

    localparam int CW = cnt_width(DOOR_CYC, TIMEOUT);
    localparam logic [CW-1:0] DOOR_LIM = CW'(DOOR_CYC);
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);

    state_t      state, state_nxt;
    dir_t        dir, dir_nxt;
    logic        pend_exit, pend_enter;
    logic        clr_exit, clr_enter;
    logic        tmr_load, tmr_done;
    logic [CW-1:0] tmr_limit;

    // One timer serves both door dwell and pump timeout; it restarts on
    // every state change so each timed state sees a fresh count.
    assign tmr_load  = (state_nxt != state);
    assign tmr_limit = (state == INNER_OPEN || state == OUTER_OPEN) ? DOOR_LIM : TO_LIM;

    airlock_cycle_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= READY_P;
            dir   <= NONE;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
        end
    end

    // Flags are set by the request edge itself; a completing trip clears
    // its flag, and a request seen at that same edge is a duplicate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_exit  <= 1'b0;
            pend_enter <= 1'b0;
        end else if (state != FAULT) begin
            pend_exit  <= clr_exit  ? 1'b0 : (pend_exit  | req_exit);
            pend_enter <= clr_enter ? 1'b0 : (pend_enter | req_enter);
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        clr_exit  = 1'b0;
        clr_enter = 1'b0;
        case (state)
            READY_P: begin
                if (pend_exit) begin
                    state_nxt = INNER_OPEN;
                    dir_nxt   = OUT;
                end else if (pend_enter) begin
                    state_nxt = EVAC;
                    dir_nxt   = NONE;
                end
            end
            INNER_OPEN: begin
                if (tmr_done) begin
                    if (dir == OUT) begin
                        state_nxt = EVAC;
                    end else begin
                        state_nxt = READY_P;
                        clr_enter = (dir == IN);
                    end
                end
            end
            EVAC: begin
                // Status met on the limit cycle still counts as success.
                if (evacuated && !pressurized)
                    state_nxt = (dir == OUT) ? OUTER_OPEN : READY_V;
                else if (tmr_done)
                    state_nxt = FAULT;
            end
            READY_V: begin
                if (pend_enter) begin
                    state_nxt = OUTER_OPEN;
                    dir_nxt   = IN;
                end else if (pend_exit) begin
                    state_nxt = PRESS;
                    dir_nxt   = NONE;
                end
            end
            OUTER_OPEN: begin
                if (tmr_done) begin
                    if (dir == IN) begin
                        state_nxt = PRESS;
                    end else begin
                        state_nxt = READY_V;
                        clr_exit  = (dir == OUT);
                    end
                end
            end
            PRESS: begin
                if (pressurized && !evacuated)
                    state_nxt = (dir == IN) ? INNER_OPEN : READY_P;
                else if (tmr_done)
                    state_nxt = FAULT;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    // Moore decode: exactly one actuator per state keeps the interlock
    // structural rather than checked.
    always_comb begin
        evacuate_ctrl   = 1'b0;
        pressurize_ctrl = 1'b0;
        inner_door_open = 1'b0;
        outer_door_open = 1'b0;
        at_vacuum       = 1'b0;
        busy            = 1'b0;
        fault           = 1'b0;
        case (state)
            INNER_OPEN: begin inner_door_open = 1'b1; busy = 1'b1; end
            EVAC:       begin evacuate_ctrl   = 1'b1; busy = 1'b1; end
            READY_V:    at_vacuum = 1'b1;
            OUTER_OPEN: begin outer_door_open = 1'b1; busy = 1'b1; end
            PRESS:      begin pressurize_ctrl = 1'b1; busy = 1'b1; end
            FAULT:      fault = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with DOOR_CYC=4, TIMEOUT=16.
// Output vector order: {evac, press, inner, outer, at_vacuum, busy, fault}.
module tb_airlock_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_exit = 1'b0;
    logic req_enter = 1'b0;
    logic pressurized = 1'b1;
    logic evacuated = 1'b0;
    logic evacuate_ctrl, pressurize_ctrl, inner_door_open, outer_door_open;
    logic at_vacuum, busy, fault;
    logic [6:0] outs;

    int errs = 0;
    int checks = 0;

    localparam logic [6:0] O_RP  = 7'b0000000;
    localparam logic [6:0] O_IN  = 7'b0010010;
    localparam logic [6:0] O_EV  = 7'b1000010;
    localparam logic [6:0] O_RV  = 7'b0000100;
    localparam logic [6:0] O_OUT = 7'b0001010;
    localparam logic [6:0] O_PR  = 7'b0100010;
    localparam logic [6:0] O_F   = 7'b0000001;

    airlock_sequencer #(.DOOR_CYC(4), .TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_exit        (req_exit),
        .req_enter       (req_enter),
        .pressurized     (pressurized),
        .evacuated       (evacuated),
        .evacuate_ctrl   (evacuate_ctrl),
        .pressurize_ctrl (pressurize_ctrl),
        .inner_door_open (inner_door_open),
        .outer_door_open (outer_door_open),
        .at_vacuum       (at_vacuum),
        .busy            (busy),
        .fault           (fault)
    );

    assign outs = {evacuate_ctrl, pressurize_ctrl, inner_door_open, outer_door_open,
                   at_vacuum, busy, fault};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_chk(input string tag, input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, outs, v);
        end
    endtask

    task automatic pulse_req(input logic ex, input logic en);
        req_exit  = ex;
        req_enter = en;
        tick();
        req_exit  = 1'b0;
        req_enter = 1'b0;
    endtask

    task automatic set_press();
        pressurized = 1'b1;
        evacuated   = 1'b0;
    endtask

    task automatic set_vac();
        pressurized = 1'b0;
        evacuated   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async", outs, O_RP);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_release", outs, O_RP);
    endtask

    // Interlock invariants, sampled every cycle away from the active edge.
    always @(negedge clk) begin
        chk("ilock_doors", 7'(inner_door_open & outer_door_open), 7'd0);
        chk("ilock_ctrl_door", 7'((evacuate_ctrl | pressurize_ctrl) &
                                  (inner_door_open | outer_door_open)), 7'd0);
        chk("ilock_ctrls", 7'(evacuate_ctrl & pressurize_ctrl), 7'd0);
    end

    initial begin
        // Exit trip: pressurized side -> vacuum side.
        do_reset();
        pulse_req(1'b1, 1'b0);
        chk("exit_wait", outs, O_RP);
        hold_chk("exit_inner", O_IN, 4);
        hold_chk("exit_evac", O_EV, 5);
        set_vac();
        hold_chk("exit_outer", O_OUT, 4);
        hold_chk("exit_rv", O_RV, 3);

        // Enter trip starting from a pressurized chamber.
        set_press();
        do_reset();
        pulse_req(1'b0, 1'b1);
        chk("ent_wait", outs, O_RP);
        hold_chk("ent_evac", O_EV, 3);
        set_vac();
        hold_chk("ent_rv", O_RV, 1);
        hold_chk("ent_outer", O_OUT, 4);
        hold_chk("ent_press", O_PR, 2);
        set_press();
        hold_chk("ent_inner", O_IN, 4);
        hold_chk("ent_rp", O_RP, 3);

        // Simultaneous requests: exit first, then enter without pumping down.
        pulse_req(1'b1, 1'b1);
        chk("both_wait", outs, O_RP);
        hold_chk("both_inner1", O_IN, 4);
        hold_chk("both_evac", O_EV, 2);
        set_vac();
        hold_chk("both_outer1", O_OUT, 4);
        hold_chk("both_rv", O_RV, 1);
        hold_chk("both_outer2", O_OUT, 4);
        hold_chk("both_press", O_PR, 2);
        set_press();
        hold_chk("both_inner2", O_IN, 4);
        hold_chk("both_rp", O_RP, 3);

        // Status arrives on exactly the 16th wait cycle: no fault.
        pulse_req(1'b1, 1'b0);
        chk("edge_wait", outs, O_RP);
        hold_chk("edge_inner", O_IN, 4);
        hold_chk("edge_evac", O_EV, 16);
        set_vac();
        hold_chk("edge_outer", O_OUT, 4);
        hold_chk("edge_rv", O_RV, 2);

        // Reset in the middle of OUTER_OPEN with a request latched.
        pulse_req(1'b0, 1'b1);
        chk("mid_wait", outs, O_RV);
        hold_chk("mid_outer", O_OUT, 2);
        pulse_req(1'b1, 1'b0);
        chk("mid_outer3", outs, O_OUT);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_async", outs, O_RP);
        tick();
        tick();
        rst = 1'b0;
        hold_chk("mid_rst_idle", O_RP, 5);

        // Pump timeout: evacuated never arrives.
        set_press();
        pulse_req(1'b1, 1'b0);
        chk("to_wait", outs, O_RP);
        hold_chk("to_inner", O_IN, 4);
        hold_chk("to_evac", O_EV, 16);
        tick();
        chk("to_fault", outs, O_F);
        pulse_req(1'b1, 1'b1);
        chk("to_fault_req", outs, O_F);
        set_vac();
        hold_chk("to_fault_vac", O_F, 5);
        set_press();
        pulse_req(1'b0, 1'b1);
        hold_chk("to_fault_hold", O_F, 3);
        do_reset();
        hold_chk("to_after_rst", O_RP, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
